countdown_timer: RTL and testbench

- Down-counting companion to the stopwatch's up-counter, in the same stopwatch display path.
- Loads a BCD mm:ss preset and decrements it once per second while running.
- Asserts an expiry flag at 00:00 and holds it until the next load.
- Outputs feed the same seven-segment mux and alarm logic as the up-counter's done flag.

---
 rtl/countdown_timer_pkg.sv | 24 ++
 rtl/countdown_timer_if.sv | 47 ++++
 rtl/countdown_timer_bcd_down_digit.sv | 34 +++
 rtl/countdown_timer.sv | 157 +++++++++++++++
 tb/tb_countdown_timer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Imported by the timer top level, its digit cells and its bus interface.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } timer_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
    localparam bcd_digit_t DIGIT_MAX    = 4'd9;

    function automatic bcd_digit_t clamp_digit(
        input bcd_digit_t d,
        input bcd_digit_t lim
    );
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and status bundle between the timer and the display/alarm path.
// master drives the preset and the commands; slave is the timer itself.
interface countdown_timer_if;
    import timer_pkg::*;

    logic       load;
    logic       start;
    logic       stop;
    logic [7:0] preset_min;
    logic [7:0] preset_sec;

    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       tick_sec;
    logic       expired;
    logic       expire_pulse;

    modport master (
        output load,
        output start,
        output stop,
        output preset_min,
        output preset_sec,
        input  min_bcd,
        input  sec_bcd,
        input  running,
        input  tick_sec,
        input  expired,
        input  expire_pulse
    );

    modport slave (
        input  load,
        input  start,
        input  stop,
        input  preset_min,
        input  preset_sec,
        output min_bcd,
        output sec_bcd,
        output running,
        output tick_sec,
        output expired,
        output expire_pulse
    );

endinterface

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit; chained via borrow to form mm:ss.
// The chain decrements only where en and the incoming borrow coincide.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       borrow_in,
    input  logic       load,
    input  bcd_digit_t load_val,
    output bcd_digit_t digit,
    output logic       borrow_out,
    output logic       is_zero
);

    localparam bcd_digit_t TOP = bcd_digit_t'(MOD - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit <= '0;
        end else if (load) begin
            digit <= load_val;
        end else if (en && borrow_in) begin
            digit <= is_zero ? TOP : digit - 4'd1;
        end
    end

    assign is_zero    = (digit == '0);
    assign borrow_out = borrow_in && is_zero;

endmodule

// File: rtl/countdown_timer.sv
// mm:ss BCD countdown timer: prescaler, run/pause FSM and expiry flagging.
// Counts stop at 00:00; expired holds until the next load or reset.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int PRESC_W  = $clog2(TICK_DIV)
) (
    input logic              clk,
    input logic              reset,
    countdown_timer_if.slave bus
);

    localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(TICK_DIV - 1);

    timer_state_t       state;
    logic [PRESC_W-1:0] presc;
    logic               running_q;
    logic               tick_q;
    logic               expired_q;
    logic               pulse_q;

    bcd_digit_t su_val;
    bcd_digit_t st_val;
    bcd_digit_t mu_val;
    bcd_digit_t mt_val;

    bcd_digit_t su_d;
    bcd_digit_t st_d;
    bcd_digit_t mu_d;
    bcd_digit_t mt_d;

    logic [3:0] z;
    logic       b_su;
    logic       b_st;
    logic       b_mu;
    logic       b_mt;

    logic all_zero;
    logic run_wrap;
    logic dec;
    logic last_sec;
    logic start_ok;

    always_comb begin
        su_val = clamp_digit(bus.preset_sec[3:0], DIGIT_MAX);
        st_val = clamp_digit(bus.preset_sec[7:4], SEC_TENS_MAX);
        mu_val = clamp_digit(bus.preset_min[3:0], DIGIT_MAX);
        mt_val = clamp_digit(bus.preset_min[7:4], DIGIT_MAX);
    end

    // The seconds-units cell always sees a borrow, so the top borrow
    // is high exactly when every digit is zero; that blocks underflow.
    bcd_down_digit #(.MOD(10)) u_su (
        .clk       (clk),
        .reset     (reset),
        .en        (dec),
        .borrow_in (1'b1),
        .load      (bus.load),
        .load_val  (su_val),
        .digit     (su_d),
        .borrow_out(b_su),
        .is_zero   (z[0])
    );

    bcd_down_digit #(.MOD(6)) u_st (
        .clk       (clk),
        .reset     (reset),
        .en        (dec),
        .borrow_in (b_su),
        .load      (bus.load),
        .load_val  (st_val),
        .digit     (st_d),
        .borrow_out(b_st),
        .is_zero   (z[1])
    );

    bcd_down_digit #(.MOD(10)) u_mu (
        .clk       (clk),
        .reset     (reset),
        .en        (dec),
        .borrow_in (b_st),
        .load      (bus.load),
        .load_val  (mu_val),
        .digit     (mu_d),
        .borrow_out(b_mu),
        .is_zero   (z[2])
    );

    bcd_down_digit #(.MOD(10)) u_mt (
        .clk       (clk),
        .reset     (reset),
        .en        (dec),
        .borrow_in (b_mu),
        .load      (bus.load),
        .load_val  (mt_val),
        .digit     (mt_d),
        .borrow_out(b_mt),
        .is_zero   (z[3])
    );

    assign all_zero = &z;
    assign run_wrap = (state == RUN) && !bus.load && !bus.stop
                      && (presc == PRESC_TOP);
    assign dec      = run_wrap && !b_mt;
    assign last_sec = dec && (&z[3:1]) && (su_d == 4'd1);
    assign start_ok = bus.start && !all_zero
                      && ((state == IDLE) || (state == PAUSE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            presc     <= '0;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            tick_q  <= dec;
            pulse_q <= last_sec;
            if (bus.load) begin
                state     <= IDLE;
                presc     <= '0;
                running_q <= 1'b0;
                expired_q <= 1'b0;
            end else if (bus.stop) begin
                // Prescaler is held so a resume finishes the partial second.
                if (state == RUN) begin
                    state     <= PAUSE;
                    running_q <= 1'b0;
                end
            end else if (start_ok) begin
                state     <= RUN;
                running_q <= 1'b1;
            end else if (state == RUN) begin
                if (presc == PRESC_TOP) begin
                    presc <= '0;
                    if (last_sec) begin
                        state     <= DONE;
                        running_q <= 1'b0;
                        expired_q <= 1'b1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    assign bus.min_bcd      = {mt_d, mu_d};
    assign bus.sec_bcd      = {st_d, su_d};
    assign bus.running      = running_q;
    assign bus.tick_sec     = tick_q;
    assign bus.expired      = expired_q;
    assign bus.expire_pulse = pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer with a 4-cycle second.
// Expected ticks are queued at start and matched when tick_sec fires.
module tb_countdown_timer;

    localparam int TD = 4;

    typedef struct {
        int          at;
        logic [15:0] cnt;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    countdown_timer_if bus();

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic push(int at, logic [15:0] cnt, logic last);
        exp_t e;
        e.at = at;
        e.cnt = cnt;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(logic [7:0] m, logic [7:0] s);
        bus.preset_min = m;
        bus.preset_sec = s;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic do_start(output int s);
        bus.start = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.tick_sec === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexp_tick", 32'(bus.tick_sec), 32'd0);
            end else begin
                e = sb.pop_front();
                check("tick_cyc", cyc, e.at);
                check("tick_cnt", {bus.min_bcd, bus.sec_bcd}, 32'(e.cnt));
                check("tick_exp", 32'(bus.expire_pulse), 32'(e.last));
            end
        end else if (bus.expire_pulse !== 1'b0) begin
            check("lone_exp", 32'(bus.expire_pulse), 32'd0);
        end
    end

    function automatic logic [31:0] outs();
        return {10'd0, bus.min_bcd, bus.sec_bcd, bus.running,
                bus.tick_sec, bus.expired, bus.expire_pulse};
    endfunction

    initial begin
        int s;
        int r;
        bus.load = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.preset_min = '0;
        bus.preset_sec = '0;
        #1;
        check("reset_state", outs(), 32'd0);
        idle(2);
        reset = 1'b0;
        idle(1);

        // 00:03 runs out after three ticks
        do_load(8'h00, 8'h03);
        do_start(s);
        push(s + 4, 16'h0002, 1'b0);
        push(s + 8, 16'h0001, 1'b0);
        push(s + 12, 16'h0000, 1'b1);
        idle(2);
        check("t1_running", 32'(bus.running), 32'd1);
        check("t1_not_exp", 32'(bus.expired), 32'd0);
        idle(14);
        check("t1_expired", 32'(bus.expired), 32'd1);
        check("t1_stopped", 32'(bus.running), 32'd0);
        check("t1_zero", {bus.min_bcd, bus.sec_bcd}, 32'h0000);

        // borrow chains
        do_load(8'h01, 8'h00);
        do_start(s);
        push(s + 4, 16'h0059, 1'b0);
        idle(4);
        do_load(8'h10, 8'h00);
        do_start(s);
        push(s + 4, 16'h0959, 1'b0);
        idle(4);
        do_load(8'h00, 8'h00);
        check("t2_sb_empty", sb.size(), 32'd0);

        // pause keeps the partial second; start+stop pauses
        do_load(8'h00, 8'h05);
        do_start(s);
        idle(2);
        bus.stop = 1'b1;
        idle(10);
        bus.stop = 1'b0;
        check("t3_paused", 32'(bus.running), 32'd0);
        check("t3_hold", {bus.min_bcd, bus.sec_bcd}, 32'h0005);
        do_start(r);
        push(r + 2, 16'h0004, 1'b0);
        check("t3_resumed", 32'(bus.running), 32'd1);
        idle(3);
        bus.start = 1'b1;
        bus.stop = 1'b1;
        idle(1);
        bus.start = 1'b0;
        bus.stop = 1'b0;
        check("t3_both_pause", 32'(bus.running), 32'd0);
        idle(8);
        check("t3_frozen", {bus.min_bcd, bus.sec_bcd}, 32'h0004);

        // start at 00:00 ignored; load mid-run restarts prescaler
        do_load(8'h00, 8'h00);
        do_start(s);
        idle(8);
        check("t4_idle", 32'(bus.running), 32'd0);
        check("t4_no_exp", 32'(bus.expired), 32'd0);
        do_load(8'h00, 8'h12);
        do_start(s);
        idle(2);
        do_load(8'h00, 8'h09);
        check("t4_reload_idle", 32'(bus.running), 32'd0);
        check("t4_reload_cnt", {bus.min_bcd, bus.sec_bcd}, 32'h0009);
        do_start(s);
        push(s + 4, 16'h0008, 1'b0);
        idle(4);
        do_load(8'h00, 8'h00);

        // preset clamping
        do_load(8'h9F, 8'h7A);
        check("t5_clamp_a", {bus.min_bcd, bus.sec_bcd}, 32'h9959);
        do_load(8'hA5, 8'h6A);
        check("t5_clamp_b", {bus.min_bcd, bus.sec_bcd}, 32'h9559);
        do_load(8'h42, 8'h37);
        check("t5_noclamp", {bus.min_bcd, bus.sec_bcd}, 32'h4237);

        // async reset mid-run
        do_load(8'h00, 8'h03);
        do_start(s);
        push(s + 4, 16'h0002, 1'b0);
        idle(5);
        check("t6_pre_reset", {bus.min_bcd, bus.sec_bcd}, 32'h0002);
        #1 reset = 1'b1;
        #1;
        check("t6_async_rst", outs(), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(16);
        check("t6_no_exp", 32'(bus.expired), 32'd0);

        // start in DONE ignored; load clears expired
        do_load(8'h00, 8'h01);
        do_start(s);
        push(s + 4, 16'h0000, 1'b1);
        idle(6);
        check("t7_done", 32'(bus.expired), 32'd1);
        do_start(s);
        idle(6);
        check("t7_still_done", {bus.running, bus.expired}, 32'b01);
        check("t7_zero", {bus.min_bcd, bus.sec_bcd}, 32'h0000);
        do_load(8'h00, 8'h07);
        check("t7_cleared", 32'(bus.expired), 32'd0);
        check("t7_loaded", {bus.min_bcd, bus.sec_bcd}, 32'h0007);

        idle(2);
        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
